cmd_router: RTL and testbench

Byte-stream command router between the PC link (UART/USB byte interface) and the channelised master/slave bus used by the function-testing and register blocks. Parses framed host commands and fans payload bytes out as `master_data` with a one-hot `valid_bus` strobe. Round-robins over slave `have_msg_bus` requests and serialises each pending slave message back to the host as a framed reply, pulling bytes with `rdreq_bus`.

---
 rtl/cmd_router_pkg.sv | 37 +++
 rtl/cmd_router_rr_arbiter.sv | 30 +++
 rtl/cmd_router.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_cmd_router.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_router_pkg.sv
// Shared types and defaults for the host command router.
// Holds the SYNC/N_CH/TIMEOUT defaults and the RX/TX state encodings.
// Option macro: CMD_ROUTER_CSUM_EN adds the R_CSUM/T_CSUM states.
package cmd_router_pkg;

    localparam int         N_CH_DEF    = 5;
    localparam logic [7:0] SYNC_DEF    = 8'hAA;
    localparam int         TIMEOUT_DEF = 50000;

    typedef enum logic [2:0] {
        R_HUNT,
        R_ADDR,
        R_LEN,
`ifdef CMD_ROUTER_CSUM_EN
        R_PAY,
        R_CSUM
`else
        R_PAY
`endif
    } rx_state_e;

    typedef enum logic [2:0] {
        T_IDLE,
        T_SYNC,
        T_ADDR,
        T_LEN,
        T_REQ,
        T_WAIT,
`ifdef CMD_ROUTER_CSUM_EN
        T_DATA,
        T_CSUM
`else
        T_DATA
`endif
    } tx_state_e;

endpackage

// File: rtl/cmd_router_rr_arbiter.sv
// Combinational round-robin arbiter for the router's reply channels.
// Ports: i_req request vector, i_start first channel to search (one past
// the last grant), o_grant one-hot winner, o_valid any request seen.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int AW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [AW-1:0] i_start,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    int w_idx;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = int'(i_start) + i;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_router.sv
// Byte-stream router: host frames fan out to channels, channel replies are
// framed back to the host in round-robin order.
// Ports: n_rst/sys_clk; rx_data/rx_valid host bytes in; tx_data/tx_valid/
// tx_ready host bytes out; master_data/valid_bus channel payload strobe;
// have_msg_bus/len_bus/rdreq_bus/slave_data_bus channel reply FIFOs;
// rx_err pulse on RX frame error.
// Option macro: CMD_ROUTER_CSUM_EN adds XOR checksum bytes to both links.
module cmd_router
    import cmd_router_pkg::*;
#(
    parameter int         N_CH    = N_CH_DEF,
    parameter logic [7:0] SYNC    = SYNC_DEF,
    parameter int         TIMEOUT = TIMEOUT_DEF
) (
    input  logic              n_rst,
    input  logic              sys_clk,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        master_data,
    output logic [N_CH-1:0]   valid_bus,
    input  logic [N_CH-1:0]   have_msg_bus,
    input  logic [8*N_CH-1:0] len_bus,
    output logic [N_CH-1:0]   rdreq_bus,
    input  logic [8*N_CH-1:0] slave_data_bus,
    output logic              rx_err
);

    localparam int            AW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [7:0]    NCH8    = 8'(N_CH);
    localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [AW-1:0] LAST_CH = AW'(N_CH - 1);

    // ---------------- RX ----------------
    rx_state_e        r_rx_state, w_rx_state;
    logic [AW-1:0]    r_addr, w_addr;
    logic             r_bad, w_bad;
    logic [7:0]       r_cnt, w_cnt;
    logic [15:0]      r_idle, w_idle;
    logic [7:0]       r_master_data, w_master_data;
    logic [N_CH-1:0]  r_valid_bus, w_valid_bus;
    logic             r_rx_err, w_rx_err;
`ifdef CMD_ROUTER_CSUM_EN
    logic [7:0]       r_rx_csum, w_rx_csum;
`endif

    always_comb begin
        w_rx_state    = r_rx_state;
        w_addr        = r_addr;
        w_bad         = r_bad;
        w_cnt         = r_cnt;
        w_master_data = r_master_data;
        w_valid_bus   = '0;
        w_rx_err      = 1'b0;
`ifdef CMD_ROUTER_CSUM_EN
        w_rx_csum     = r_rx_csum;
`endif
        w_idle = (rx_valid || r_rx_state == R_HUNT) ? '0 : r_idle + 16'd1;

        if (!rx_valid && r_rx_state != R_HUNT && r_idle == TO_LAST) begin
            w_rx_state = R_HUNT;
            w_rx_err   = 1'b1;
            w_idle     = '0;
        end else if (rx_valid) begin
            unique case (r_rx_state)
                R_HUNT: begin
                    if (rx_data == SYNC) w_rx_state = R_ADDR;
                end
                R_ADDR: begin
                    w_addr     = rx_data[AW-1:0];
                    w_bad      = (rx_data >= NCH8);
                    w_rx_state = R_LEN;
`ifdef CMD_ROUTER_CSUM_EN
                    w_rx_csum  = rx_data;
`endif
                end
                R_LEN: begin
                    w_cnt = rx_data;
`ifdef CMD_ROUTER_CSUM_EN
                    w_rx_csum = r_rx_csum ^ rx_data;
                    w_rx_state = (rx_data == 8'd0) ? R_CSUM : R_PAY;
`else
                    if (rx_data == 8'd0) begin
                        w_rx_state = R_HUNT;
                        w_rx_err   = r_bad;
                    end else begin
                        w_rx_state = R_PAY;
                    end
`endif
                end
                R_PAY: begin
                    if (!r_bad) begin
                        w_master_data = rx_data;
                        w_valid_bus   = N_CH'(1) << r_addr;
                    end
                    w_cnt = r_cnt - 8'd1;
`ifdef CMD_ROUTER_CSUM_EN
                    w_rx_csum = r_rx_csum ^ rx_data;
                    if (r_cnt == 8'd1) w_rx_state = R_CSUM;
`else
                    if (r_cnt == 8'd1) begin
                        w_rx_state = R_HUNT;
                        w_rx_err   = r_bad;
                    end
`endif
                end
`ifdef CMD_ROUTER_CSUM_EN
                R_CSUM: begin
                    w_rx_state = R_HUNT;
                    w_rx_err   = r_bad || (rx_data != r_rx_csum);
                end
`endif
                default: w_rx_state = R_HUNT;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_state    <= R_HUNT;
            r_addr        <= '0;
            r_bad         <= 1'b0;
            r_cnt         <= '0;
            r_idle        <= '0;
            r_master_data <= '0;
            r_valid_bus   <= '0;
            r_rx_err      <= 1'b0;
`ifdef CMD_ROUTER_CSUM_EN
            r_rx_csum     <= '0;
`endif
        end else begin
            r_rx_state    <= w_rx_state;
            r_addr        <= w_addr;
            r_bad         <= w_bad;
            r_cnt         <= w_cnt;
            r_idle        <= w_idle;
            r_master_data <= w_master_data;
            r_valid_bus   <= w_valid_bus;
            r_rx_err      <= w_rx_err;
`ifdef CMD_ROUTER_CSUM_EN
            r_rx_csum     <= w_rx_csum;
`endif
        end
    end

    assign master_data = r_master_data;
    assign valid_bus   = r_valid_bus;
    assign rx_err      = r_rx_err;

    // ---------------- TX ----------------
    tx_state_e        r_tx_state, w_tx_state;
    logic [AW-1:0]    r_grant, w_grant;
    logic [AW-1:0]    r_ptr, w_ptr;
    logic [7:0]       r_tx_len, w_tx_len;
    logic [7:0]       r_tx_data, w_tx_data;
    logic             r_tx_valid, w_tx_valid;
    logic [N_CH-1:0]  r_rdreq, w_rdreq;
`ifdef CMD_ROUTER_CSUM_EN
    logic [7:0]       r_tx_csum, w_tx_csum;
`endif

    logic [N_CH-1:0]  w_req;
    logic [N_CH-1:0]  w_gnt;
    logic             w_arb_vld;
    logic [AW-1:0]    w_gnt_idx;
    logic             w_hs;

    // A zero-length reply has nothing to frame, so it never competes.
    always_comb begin
        w_req = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_req[k] = have_msg_bus[k] && (len_bus[8*k +: 8] != 8'd0);
        end
    end

    rr_arbiter #(
        .N  (N_CH),
        .AW (AW)
    ) u_arb (
        .i_req   (w_req),
        .i_start (r_ptr),
        .o_grant (w_gnt),
        .o_valid (w_arb_vld)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_gnt[k]) w_gnt_idx = AW'(k);
        end
    end

    assign w_hs = r_tx_valid && tx_ready;

    always_comb begin
        w_tx_state = r_tx_state;
        w_grant    = r_grant;
        w_ptr      = r_ptr;
        w_tx_len   = r_tx_len;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;
        w_rdreq    = '0;
`ifdef CMD_ROUTER_CSUM_EN
        w_tx_csum  = r_tx_csum;
`endif
        unique case (r_tx_state)
            T_IDLE: begin
                if (w_arb_vld) begin
                    w_grant    = w_gnt_idx;
                    w_tx_len   = len_bus[{w_gnt_idx, 3'b000} +: 8];
                    w_ptr      = (w_gnt_idx == LAST_CH) ? '0
                                                        : w_gnt_idx + 1'b1;
                    w_tx_data  = SYNC;
                    w_tx_valid = 1'b1;
                    w_tx_state = T_SYNC;
                end
            end
            T_SYNC: begin
                if (w_hs) begin
                    w_tx_data  = 8'(r_grant);
                    w_tx_state = T_ADDR;
`ifdef CMD_ROUTER_CSUM_EN
                    w_tx_csum  = 8'(r_grant);
`endif
                end
            end
            T_ADDR: begin
                if (w_hs) begin
                    w_tx_data  = r_tx_len;
                    w_tx_state = T_LEN;
`ifdef CMD_ROUTER_CSUM_EN
                    w_tx_csum  = r_tx_csum ^ r_tx_len;
`endif
                end
            end
            T_LEN: begin
                if (w_hs) begin
                    w_tx_valid = 1'b0;
                    w_rdreq    = N_CH'(1) << r_grant;
                    w_tx_state = T_REQ;
                end
            end
            T_REQ: w_tx_state = T_WAIT;
            T_WAIT: begin
                w_tx_data  = slave_data_bus[{r_grant, 3'b000} +: 8];
                w_tx_valid = 1'b1;
                w_tx_state = T_DATA;
            end
            T_DATA: begin
                if (w_hs) begin
                    w_tx_len = r_tx_len - 8'd1;
`ifdef CMD_ROUTER_CSUM_EN
                    w_tx_csum = r_tx_csum ^ r_tx_data;
`endif
                    if (r_tx_len != 8'd1) begin
                        w_tx_valid = 1'b0;
                        w_rdreq    = N_CH'(1) << r_grant;
                        w_tx_state = T_REQ;
                    end else begin
`ifdef CMD_ROUTER_CSUM_EN
                        w_tx_data  = r_tx_csum ^ r_tx_data;
                        w_tx_state = T_CSUM;
`else
                        w_tx_valid = 1'b0;
                        w_tx_state = T_IDLE;
`endif
                    end
                end
            end
`ifdef CMD_ROUTER_CSUM_EN
            T_CSUM: begin
                if (w_hs) begin
                    w_tx_valid = 1'b0;
                    w_tx_state = T_IDLE;
                end
            end
`endif
            default: begin
                w_tx_valid = 1'b0;
                w_tx_state = T_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_state <= T_IDLE;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_tx_len   <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rdreq    <= '0;
`ifdef CMD_ROUTER_CSUM_EN
            r_tx_csum  <= '0;
`endif
        end else begin
            r_tx_state <= w_tx_state;
            r_grant    <= w_grant;
            r_ptr      <= w_ptr;
            r_tx_len   <= w_tx_len;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_rdreq    <= w_rdreq;
`ifdef CMD_ROUTER_CSUM_EN
            r_tx_csum  <= w_tx_csum;
`endif
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign rdreq_bus = r_rdreq;

endmodule

// File: tb/tb_cmd_router.sv
// Directed bench for cmd_router: RX routing, errors, timeout,
// round-robin TX framing and TX backpressure.
module tb_cmd_router;

    localparam int N  = 5;
    localparam int TO = 40;

    logic           n_rst = 1'b0;
    logic           sys_clk = 1'b0;
    logic [7:0]     rx_data = '0;
    logic           rx_valid = 1'b0;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b1;
    logic [7:0]     master_data;
    logic [N-1:0]   valid_bus;
    logic [N-1:0]   have_msg_bus;
    logic [8*N-1:0] len_bus;
    logic [N-1:0]   rdreq_bus;
    logic [8*N-1:0] slave_data_bus = '0;
    logic           rx_err;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    cmd_router #(
        .N_CH    (N),
        .SYNC    (8'hAA),
        .TIMEOUT (TO)
    ) dut (
        .n_rst          (n_rst),
        .sys_clk        (sys_clk),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .master_data    (master_data),
        .valid_bus      (valid_bus),
        .have_msg_bus   (have_msg_bus),
        .len_bus        (len_bus),
        .rdreq_bus      (rdreq_bus),
        .slave_data_bus (slave_data_bus),
        .rx_err         (rx_err)
    );

    // Channel FIFO model: non-show-ahead, data one cycle after rdreq.
    logic [7:0] fifo [N][16];
    int         wr [N] = '{default: 0};
    int         rd [N] = '{default: 0};

    always @(posedge sys_clk) begin
        for (int k = 0; k < N; k++) begin
            if (rdreq_bus[k]) begin
                slave_data_bus[8*k +: 8] <= fifo[k][rd[k] % 16];
                rd[k] <= rd[k] + 1;
            end
        end
    end

    always_comb begin
        have_msg_bus = '0;
        len_bus      = '0;
        for (int k = 0; k < N; k++) begin
            have_msg_bus[k]   = (wr[k] != rd[k]);
            len_bus[8*k +: 8] = 8'(wr[k] - rd[k]);
        end
    end

    // Monitors, sampled on the falling edge.
    logic [N-1:0] vb_q [$];
    logic [7:0]   md_q [$];
    logic [7:0]   txq  [$];
    int           n_err = 0;
    int           n_rdreq = 0;
    int           rdreq_bad = 0;
    int           unstable = 0;
    logic [N-1:0] prev_rdreq = '0;
    logic         prev_hold = 1'b0;
    logic [7:0]   prev_data = '0;

    always @(negedge sys_clk) begin
        if (valid_bus != '0) begin
            vb_q.push_back(valid_bus);
            md_q.push_back(master_data);
        end
        if (rx_err) n_err++;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (rdreq_bus != '0) begin
            n_rdreq++;
            if (prev_rdreq != '0 || $countones(rdreq_bus) != 1)
                rdreq_bad++;
        end
        if (prev_hold && (!tx_valid || tx_data != prev_data)) unstable++;
        prev_hold  = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_rdreq = rdreq_bus;
    end

    task automatic send(input logic [7:0] b);
        @(posedge sys_clk);
        #1 rx_data = b;
        rx_valid = 1'b1;
        @(posedge sys_clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic load(input int ch, input logic [7:0] b);
        fifo[ch][wr[ch] % 16] = b;
        wr[ch] = wr[ch] + 1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic test_reset;
        settle(3);
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx_data got=%h want=00", tx_data);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx_valid got=%b want=0", tx_valid);
        end
        checks++;
        if (master_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_master_data got=%h want=00", master_data);
        end
        checks++;
        if (valid_bus !== 5'b0) begin
            errors++;
            $display("FAIL reset_valid_bus got=%b want=00000", valid_bus);
        end
        checks++;
        if (rdreq_bus !== 5'b0) begin
            errors++;
            $display("FAIL reset_rdreq got=%b want=00000", rdreq_bus);
        end
        checks++;
        if (rx_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_err got=%b want=0", rx_err);
        end
        @(posedge sys_clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic test_rx_route;
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        int b = vb_q.size();
        int e = n_err;
        send(8'hAA); send(8'h02); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
`ifdef CMD_ROUTER_CSUM_EN
        send(8'h01);
`endif
        settle(3);
        checks++;
        if (vb_q.size() - b !== 3) begin
            errors++;
            $display("FAIL rx_route_count got=%0d want=3", vb_q.size() - b);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (vb_q[b+i] !== 5'b00100) begin
                    errors++;
                    $display("FAIL rx_route_vb%0d got=%b want=00100",
                             i, vb_q[b+i]);
                end
                checks++;
                if (md_q[b+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rx_route_md%0d got=%h want=%h",
                             i, md_q[b+i], exp[i]);
                end
            end
        end
        checks++;
        if (n_err - e !== 0) begin
            errors++;
            $display("FAIL rx_route_err got=%0d want=0", n_err - e);
        end
    endtask

    task automatic test_len0;
        int b = vb_q.size();
        int e = n_err;
        send(8'hAA); send(8'h02); send(8'h00);
`ifdef CMD_ROUTER_CSUM_EN
        send(8'h02);
`endif
        settle(3);
        checks++;
        if (vb_q.size() - b !== 0) begin
            errors++;
            $display("FAIL len0_strobes got=%0d want=0", vb_q.size() - b);
        end
        checks++;
        if (n_err - e !== 0) begin
            errors++;
            $display("FAIL len0_err got=%0d want=0", n_err - e);
        end
    endtask

    task automatic test_bad_addr;
        int b = vb_q.size();
        int e = n_err;
        send(8'hAA); send(8'h07); send(8'h02);
        send(8'h55); send(8'h66);
`ifdef CMD_ROUTER_CSUM_EN
        send(8'h36);
`endif
        settle(3);
        checks++;
        if (vb_q.size() - b !== 0) begin
            errors++;
            $display("FAIL bad_addr_strobes got=%0d want=0", vb_q.size() - b);
        end
        checks++;
        if (n_err - e !== 1) begin
            errors++;
            $display("FAIL bad_addr_err got=%0d want=1", n_err - e);
        end
        send(8'hAA); send(8'h00); send(8'h01); send(8'h77);
`ifdef CMD_ROUTER_CSUM_EN
        send(8'h76);
`endif
        settle(3);
        checks++;
        if (vb_q.size() - b !== 1) begin
            errors++;
            $display("FAIL bad_addr_next_count got=%0d want=1",
                     vb_q.size() - b);
        end else begin
            checks++;
            if (vb_q[b] !== 5'b00001 || md_q[b] !== 8'h77) begin
                errors++;
                $display("FAIL bad_addr_next got=%b/%h want=00001/77",
                         vb_q[b], md_q[b]);
            end
        end
        checks++;
        if (n_err - e !== 1) begin
            errors++;
            $display("FAIL bad_addr_next_err got=%0d want=1", n_err - e);
        end
    endtask

    task automatic test_timeout;
        int b;
        int e;
        send(8'hAA); send(8'h01);
        e = n_err;
        settle(TO - 5);
        checks++;
        if (n_err - e !== 0) begin
            errors++;
            $display("FAIL timeout_early got=%0d want=0", n_err - e);
        end
        settle(10);
        checks++;
        if (n_err - e !== 1) begin
            errors++;
            $display("FAIL timeout_err got=%0d want=1", n_err - e);
        end
        b = vb_q.size();
        send(8'hAA); send(8'h01); send(8'h01); send(8'h5A);
`ifdef CMD_ROUTER_CSUM_EN
        send(8'h5A);
`endif
        settle(3);
        checks++;
        if (vb_q.size() - b !== 1) begin
            errors++;
            $display("FAIL timeout_next_count got=%0d want=1",
                     vb_q.size() - b);
        end else begin
            checks++;
            if (vb_q[b] !== 5'b00010 || md_q[b] !== 8'h5A) begin
                errors++;
                $display("FAIL timeout_next got=%b/%h want=00010/5a",
                         vb_q[b], md_q[b]);
            end
        end
        checks++;
        if (n_err - e !== 1) begin
            errors++;
            $display("FAIL timeout_next_err got=%0d want=1", n_err - e);
        end
    endtask

    task automatic test_rr_tx;
        logic [7:0] exp [$];
        int b = txq.size();
        int r = n_rdreq;
        int cyc = 0;
        exp = '{8'hAA, 8'h00, 8'h01, 8'hB0};
`ifdef CMD_ROUTER_CSUM_EN
        exp.push_back(8'hB1);
`endif
        exp.push_back(8'hAA); exp.push_back(8'h04);
        exp.push_back(8'h02); exp.push_back(8'hA1);
        exp.push_back(8'hA2);
`ifdef CMD_ROUTER_CSUM_EN
        exp.push_back(8'h05);
`endif
        @(posedge sys_clk);
        #1 tx_ready = 1'b1;
        load(4, 8'hA1); load(4, 8'hA2); load(0, 8'hB0);
        while (txq.size() - b < exp.size() && cyc < 300) begin
            @(posedge sys_clk);
            cyc++;
        end
        settle(5);
        checks++;
        if (txq.size() - b !== exp.size()) begin
            errors++;
            $display("FAIL rr_tx_len got=%0d want=%0d",
                     txq.size() - b, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (txq[b+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rr_tx_byte%0d got=%h want=%h",
                             i, txq[b+i], exp[i]);
                end
            end
        end
        checks++;
        if (n_rdreq - r !== 3) begin
            errors++;
            $display("FAIL rr_tx_rdreq got=%0d want=3", n_rdreq - r);
        end
        checks++;
        if (rdreq_bad !== 0) begin
            errors++;
            $display("FAIL rr_tx_rdreq_shape got=%0d want=0", rdreq_bad);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp [$];
        int b = txq.size();
        int r = n_rdreq;
        int cyc = 0;
        exp = '{8'hAA, 8'h01, 8'h03, 8'hC1, 8'hC2, 8'hC3};
`ifdef CMD_ROUTER_CSUM_EN
        exp.push_back(8'hC2);
`endif
        exp.push_back(8'hAA); exp.push_back(8'h03);
        exp.push_back(8'h01); exp.push_back(8'hD0);
`ifdef CMD_ROUTER_CSUM_EN
        exp.push_back(8'hD2);
`endif
        load(1, 8'hC1); load(1, 8'hC2); load(1, 8'hC3); load(3, 8'hD0);
        while (txq.size() - b < exp.size() && cyc < 1000) begin
            @(posedge sys_clk);
            #1 tx_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        tx_ready = 1'b1;
        settle(5);
        checks++;
        if (txq.size() - b !== exp.size()) begin
            errors++;
            $display("FAIL bp_len got=%0d want=%0d",
                     txq.size() - b, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (txq[b+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL bp_byte%0d got=%h want=%h",
                             i, txq[b+i], exp[i]);
                end
            end
        end
        checks++;
        if (n_rdreq - r !== 4) begin
            errors++;
            $display("FAIL bp_rdreq got=%0d want=4", n_rdreq - r);
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL bp_stable got=%0d want=0", unstable);
        end
        checks++;
        if (rdreq_bad !== 0) begin
            errors++;
            $display("FAIL bp_rdreq_shape got=%0d want=0", rdreq_bad);
        end
    endtask

`ifdef CMD_ROUTER_CSUM_EN
    task automatic test_csum;
        int b = vb_q.size();
        int e = n_err;
        send(8'hAA); send(8'h03); send(8'h01); send(8'h0F); send(8'h0D);
        settle(3);
        checks++;
        if (n_err - e !== 0) begin
            errors++;
            $display("FAIL csum_good_err got=%0d want=0", n_err - e);
        end
        send(8'hAA); send(8'h03); send(8'h01); send(8'h0F); send(8'h00);
        settle(3);
        checks++;
        if (n_err - e !== 1) begin
            errors++;
            $display("FAIL csum_bad_err got=%0d want=1", n_err - e);
        end
        checks++;
        if (vb_q.size() - b !== 2) begin
            errors++;
            $display("FAIL csum_strobes got=%0d want=2", vb_q.size() - b);
        end else begin
            checks++;
            if (vb_q[b] !== 5'b01000 || md_q[b] !== 8'h0F) begin
                errors++;
                $display("FAIL csum_strobe got=%b/%h want=01000/0f",
                         vb_q[b], md_q[b]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rx_route();
        test_len0();
        test_bad_addr();
        test_timeout();
        test_rr_tx();
        test_backpressure();
`ifdef CMD_ROUTER_CSUM_EN
        test_csum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
